// File: rtl/data_router_ctrl.sv
// Address sequencer for the data router: walks the line buffer in block order,
// ping-pongs buffer banks per row-group and reports tile completion.
module data_router_ctrl #(
    parameter int POY   = 3,
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int COLW  = 28,
    parameter int GRPW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [COLW-1:0] cfg_ncol,
    input  logic [GRPW-1:0] cfg_ngrp,
    input  logic            cfg_dw,
    input  logic            buf_valid,
    input  logic            pe_ready,
    output logic [1:0]      bank,
    output logic [1:0]      row,
    output logic [COLW-1:0] col,
    output logic [1:0]      rpsel,
    output logic            dw_comp,
    output logic            addr_vld,
    output logic            blkend,
    output logic            busy,
    output logic            done
);

    // state | meaning
    // IDLE  | waiting for start; configuration may be latched
    // RUN   | walking addresses, stepping on each accepted address
    // FIN   | one-cycle done pulse, then back to IDLE

    if (KSIZE < 1 || KSIZE > 4 || POY < 1 || POX < 1 || GRPW < 2) begin : g_bad_cfg
        $error("data_router_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [1:0] RP_LAST = 2'(KSIZE - 1);

    state_t          state, state_nxt;
    logic [COLW-1:0] col_nxt, ncol_last, ncol_last_nxt;
    logic [GRPW-1:0] grp, grp_nxt, ngrp_last, ngrp_last_nxt;
    logic [1:0]      rpsel_nxt, bank_nxt;
    logic            dw_nxt;
    logic            adv, last_rp, last_col, last_grp, tile_end;

    assign addr_vld = (state == RUN) & buf_valid;
    assign adv      = addr_vld & pe_ready;
    assign last_rp  = ~dw_comp | (rpsel == RP_LAST);
    assign last_col = (col == ncol_last);
    assign last_grp = (grp == ngrp_last);
    assign blkend   = adv & last_rp & last_col;
    assign tile_end = blkend & last_grp;

    assign busy = (state == RUN);
    assign done = (state == FIN);
    assign row  = grp[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            rpsel     <= '0;
            grp       <= '0;
            bank      <= '0;
            dw_comp   <= 1'b0;
            ncol_last <= '0;
            ngrp_last <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            rpsel     <= rpsel_nxt;
            grp       <= grp_nxt;
            bank      <= bank_nxt;
            dw_comp   <= dw_nxt;
            ncol_last <= ncol_last_nxt;
            ngrp_last <= ngrp_last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        rpsel_nxt     = rpsel;
        grp_nxt       = grp;
        bank_nxt      = bank;
        dw_nxt        = dw_comp;
        ncol_last_nxt = ncol_last;
        ngrp_last_nxt = ngrp_last;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    col_nxt       = '0;
                    rpsel_nxt     = '0;
                    grp_nxt       = '0;
                    dw_nxt        = cfg_dw;
                    // A zero count means one step; store last index for the compare.
                    ncol_last_nxt = (cfg_ncol == '0) ? '0 : cfg_ncol - COLW'(1);
                    ngrp_last_nxt = (cfg_ngrp == '0) ? '0 : cfg_ngrp - GRPW'(1);
                end
            end
            RUN: begin
                if (adv) begin
                    if (!last_rp) begin
                        rpsel_nxt = rpsel + 2'd1;
                    end else begin
                        rpsel_nxt = '0;
                        if (!last_col) begin
                            col_nxt = col + COLW'(1);
                        end else begin
                            col_nxt  = '0;
                            grp_nxt  = grp + GRPW'(1);
                            bank_nxt = {1'b0, ~bank[0]};
                        end
                    end
                    if (tile_end) begin
                        state_nxt = FIN;
                        grp_nxt   = '0;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
